// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated TX FIFO.
//
// Words are accepted over a valid/ready handshake and buffered in a FIFO_DEPTH-entry FIFO.
// The serialiser pops one word per frame and sends it LSB first:
// start (0), DATA_WIDTH data bits, optional parity, then STOP_BITS stop bits (1).
// Queued frames follow each other with no idle gap. Each bit lasts
// CLK_FREQ/BAUD_RATE cycles, counting only cycles where ena_i is high.
//
// Optional feature: define UART_TX_PARITY_EN to add parity_mode_i
// (00 none, 01 even, 10 odd, 11 mark). The mode is captured when a word is popped.
//
// Ports:
//   clk_i          system clock
//   reset_i        synchronous reset, active-high
//   ena_i          bit-timing enable; low freezes the serialiser (FIFO push stays live)
//   tx_data_i      word to send
//   tx_valid_i     tx_data_i valid
//   tx_ready_o     FIFO can accept a word (not full)
//   parity_mode_i  parity select (only with UART_TX_PARITY_EN)
//   txd_o          registered serial line, idle high
//   busy_o         frame in progress
//   fifo_count_o   words queued, excluding the frame in flight
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          ena_i,
  input  logic [DATA_WIDTH-1:0]         tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                    parity_mode_i,
`endif
  output logic                          txd_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned PulseWidth = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW       = (PulseWidth > 1) ? $clog2(PulseWidth) : 1;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW     = PtrW + 1;
  localparam int unsigned BitW       = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]     count_q, count_d;
  logic                  full, empty, push, pop;
  logic [DATA_WIDTH-1:0] head_word;

  // Serialiser
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  bit_done, start_frame;

`ifdef UART_TX_PARITY_EN
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
`endif

  assign full       = (count_q == CountW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign push       = tx_valid_i && !full;
  assign head_word  = mem_q[rd_ptr_q];

  assign tx_ready_o   = !full;
  assign txd_o        = txd_q;
  assign busy_o       = busy_q;
  assign fifo_count_o = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  // Last counted cycle of the current bit.
  assign bit_done = ena_i && (cnt_q == CntW'(PulseWidth - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    txd_d       = txd_q;
    busy_d      = busy_q;
    start_frame = 1'b0;
    pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
`endif

    if (state_q != StIdle && ena_i) begin
      cnt_d = bit_done ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (ena_i && !empty) start_frame = 1'b1;
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      StData: begin
        if (bit_done) begin
          if (bit_q == BitW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = StParity;
              txd_d   = par_bit_q;
            end else begin
              state_d = StStop;
              txd_d   = 1'b1;
              bit_d   = '0;
            end
`else
            state_d = StStop;
            txd_d   = 1'b1;
            bit_d   = '0;
`endif
          end else begin
            bit_d   = bit_q + BitW'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          txd_d   = 1'b1;
          bit_d   = '0;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (bit_q == BitW'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when more data is queued.
            if (!empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) begin
      pop     = 1'b1;
      state_d = StStart;
      txd_d   = 1'b0;
      busy_d  = 1'b1;
      cnt_d   = '0;
      shift_d = head_word;
`ifdef UART_TX_PARITY_EN
      par_en_d = (parity_mode_i != 2'b00);
      case (parity_mode_i)
        2'b01:   par_bit_d = ^head_word;
        2'b10:   par_bit_d = ~^head_word;
        default: par_bit_d = 1'b1;  // mark; ignored when parity is off
      endcase
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (default parameters, 434 clocks per bit).
// A driver issues directed words and queues the expected frames; a monitor decodes txd
// in counted (ena-high) cycles and compares each finished frame against the queue head.
module tb_uart_tx_fifo;

  localparam int PW = 434;
  localparam int DW = 8;
  localparam int SB = 1;

  typedef struct packed {
    logic       has_par;
    logic       par;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, txd, busy;
  logic [3:0] fifo_count;
`ifdef UART_TX_PARITY_EN
  logic [1:0] parity_mode = 2'b00;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_gap_starts = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .ena_i        (ena),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
`ifdef UART_TX_PARITY_EN
    .parity_mode_i(parity_mode),
`endif
    .txd_o        (txd),
    .busy_o       (busy),
    .fifo_count_o (fifo_count)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic exp_t mk(input logic hp, input logic pb, input logic [7:0] d);
    exp_t e;
    e.has_par = hp;
    e.par     = pb;
    e.data    = d;
    return e;
  endfunction

  // Bit k of the result is the k-th bit on the line.
  function automatic logic [15:0] frame_bits(input exp_t e, output int nb);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1 + i] = e.data[i];
    k = 1 + DW;
    if (e.has_par) begin
      f[k] = e.par;
      k++;
    end
    k = k + SB;
    nb = k;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w, input logic hp, input logic pb);
    int guard;
    guard = 0;
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (tx_ready !== 1'b1) check("push ready timeout", 32'(tx_ready), 1);
    @(posedge clk);
    exp_q.push_back(mk(hp, pb, w));
  endtask

  task automatic drop_valid();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(busy === 1'b0 && fifo_count === 4'd0 && exp_q.size() == 0) && n < 60000) begin
      tick();
      n++;
    end
    check(name, 32'(busy === 1'b0 && fifo_count === 4'd0 && exp_q.size() == 0), 1);
  endtask

  // Monitor: decodes frames bit by bit in counted cycles, checks bit stability.
  initial begin : monitor
    logic [15:0] got, want;
    int          nb, gap, cnt, glitches;
    logic        v, en, rs;
    bit          aborted;
    exp_t        e;
    gap = 0;
    wait (mon_en);
    forever begin
      @(posedge clk);
      rs = reset;
      #1;
      if (rs || txd !== 1'b0) begin
        gap++;
        continue;
      end
      do begin
        if (gap > 0) n_gap_starts++;
        gap = 0;
        if (exp_q.size() > 0) e = exp_q[0];
        else e = mk(1'b0, 1'b0, 8'h00);
        want     = frame_bits(e, nb);
        got      = '1;
        aborted  = 1'b0;
        glitches = 0;
        for (int b = 0; b < nb && !aborted; b++) begin
          v      = txd;
          got[b] = v;
          cnt    = 0;
          while (cnt < PW && !aborted) begin
            @(posedge clk);
            en = ena;
            rs = reset;
            #1;
            if (rs) begin
              aborted = 1'b1;
            end else begin
              if (en) cnt++;
              if (cnt < PW && txd !== v) glitches++;
            end
          end
        end
        if (aborted) begin
          gap = 1;
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected frame: got bits %0h, expected no frame", got);
        end else begin
          void'(exp_q.pop_front());
          check($sformatf("frame %02h bits", e.data), 32'(got), 32'(want));
          check($sformatf("frame %02h bit timing", e.data), glitches, 0);
        end
      end while (!aborted && txd === 1'b0);
    end
  end

  initial begin : watchdog
    #1_200_000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int n, n0, rise, fall, frozen_changes, busy_n, txd_low;
    logic prev;

    // 1. Reset state, then a long idle stretch.
    repeat (3) @(posedge clk);
    #1;
    check("reset txd", 32'(txd), 1);
    check("reset busy", 32'(busy), 0);
    check("reset tx_ready", 32'(tx_ready), 1);
    check("reset fifo_count", 32'(fifo_count), 0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    txd_low = 0;
    repeat (1000) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) txd_low++;
    end
    check("idle line stays high", txd_low, 0);

    // 2. Single word 0xA5: start latency and busy length.
    push(8'hA5, 1'b0, 1'b0);
    #1;
    check("txd on push edge", 32'(txd), 1);
    check("busy on push edge", 32'(busy), 0);
    @(negedge clk);
    tx_valid = 1'b0;
    tick();
    check("start bit one clk after push", 32'(txd), 0);
    check("busy at start", 32'(busy), 1);
    n = 1;
    while (busy === 1'b1 && n < 6000) begin
      tick();
      if (busy === 1'b1) n++;
    end
    check("busy length 0xA5", n, 4340);
    wait_idle("idle after 0xA5");

    // 3. Ten words back to back: FIFO fills, ready returns after the next pop, no gaps.
    n0 = n_gap_starts;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tx_data  = 8'(i);
      tx_valid = 1'b1;
      if (i == 9) check("fifo_count when full", 32'(fifo_count), 8);
      check($sformatf("tx_ready before word %0d", i), 32'(tx_ready), 32'(i < 9));
      @(posedge clk);
      if (i < 9) exp_q.push_back(mk(1'b0, 1'b0, 8'(i)));
    end
    n = 1;
    while (n < 6000) begin
      @(negedge clk);
      if (tx_ready === 1'b1) break;
      @(posedge clk);
      n++;
    end
    check("tx_ready returns after pop", n, 4333);
    @(posedge clk);
    exp_q.push_back(mk(1'b0, 1'b0, 8'h09));
    drop_valid();
    wait_idle("idle after burst");
    check("burst frames contiguous", n_gap_starts - n0, 1);

    // 4. Freeze ena for 100 cycles inside data bit 3 of 0x3C.
    push(8'h3C, 1'b0, 1'b0);
    #1;
    prev = txd;
    rise = -1;
    fall = -1;
    frozen_changes = 0;
    busy_n = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      ena = !(k >= 1938 && k <= 2037);
      tick();
      if (busy === 1'b1) busy_n++;
      if (rise < 0 && prev === 1'b0 && txd === 1'b1) rise = k;
      else if (rise > 0 && fall < 0 && txd === 1'b0) fall = k;
      if (!ena && txd !== prev) frozen_changes++;
      prev = txd;
    end
    check("txd stable while frozen", frozen_changes, 0);
    check("data bits 2..5 run incl. freeze", fall - rise, 1836);
    check("busy length with freeze", busy_n, 4440);
    wait_idle("idle after freeze");

    // 5. Reset in the data phase of frame 1 with 3 words queued.
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b0);
    push(8'h33, 1'b0, 1'b0);
    push(8'h44, 1'b0, 1'b0);
    drop_valid();
    repeat (1000) tick();
    check("queued before reset", 32'(fifo_count), 3);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("txd after mid-frame reset", 32'(txd), 1);
    check("fifo_count after reset", 32'(fifo_count), 0);
    check("busy after reset", 32'(busy), 0);
    check("tx_ready after reset", 32'(tx_ready), 1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    txd_low = 0;
    repeat (2000) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) txd_low++;
    end
    check("no frames after reset", txd_low, 0);

`ifdef UART_TX_PARITY_EN
    // 6. Parity modes on 0x07 (three ones).
    parity_mode = 2'b01;
    push(8'h07, 1'b1, 1'b1);
    drop_valid();
    wait_idle("idle after even");
    parity_mode = 2'b10;
    push(8'h07, 1'b1, 1'b0);
    drop_valid();
    wait_idle("idle after odd");
    parity_mode = 2'b11;
    push(8'h07, 1'b1, 1'b1);
    drop_valid();
    wait_idle("idle after mark");
    parity_mode = 2'b00;
    push(8'h07, 1'b0, 1'b0);
    drop_valid();
    wait_idle("idle after none");
    parity_mode = 2'b01;
    push(8'h07, 1'b1, 1'b1);
    drop_valid();
    repeat (5) tick();
    @(negedge clk);
    parity_mode = 2'b10;
    wait_idle("idle after even with mid-frame change");
    parity_mode = 2'b00;
    push(8'h07, 1'b0, 1'b0);
    drop_valid();
    repeat (5) tick();
    @(negedge clk);
    parity_mode = 2'b11;
    wait_idle("idle after none with mid-frame change");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
